// File: rtl/bus_mux_pkg.sv
// rtl/bus_mux_pkg.sv - shared types and default widths for the bus source mux
package bus_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_SEL_W  = 3;

endpackage

// File: rtl/bus_skid_buf.sv
// rtl/bus_skid_buf.sv - 2-entry valid/ready skid buffer with a registered ready
module bus_skid_buf
    import bus_mux_pkg::*;
#(
    parameter int           W       = 27,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    skid_state_e  state_q;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         out_valid_q;

    logic accept;
    logic consume;

    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid_q && out_ready;
    assign in_ready  = in_ready_q;
    assign out_data  = out_q;
    assign out_valid = out_valid_q;

    // Ready is a pure function of the registered state, so the upstream never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q       <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !consume) begin
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (consume && !accept) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else if (accept && consume) begin
                        out_q <= in_data;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_src_mux_skid.sv
// rtl/bus_src_mux_skid.sv - N-source bus selector with fallback, sticky error and skid output
module bus_src_mux_skid
    import bus_mux_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int N_SRC       = 8,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int DEFAULT_SEL = 7,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_en,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    input  logic                    sel_err_clr,
    output logic [CNT_W-1:0]        xfer_cnt
);

    localparam int NSEL = 1 << SEL_W;
    localparam int PW   = DATA_W + SEL_W;
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

    logic [NSEL-1:0]   en_ext;
    logic              sel_ok;
    logic [SEL_W-1:0]  eff_sel;
    logic [DATA_W-1:0] eff_data;
    logic [PW-1:0]     buf_out;
    logic              accept;
    logic              consume;

    logic              sel_err_q, sel_err_d;
    logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

    // Zero-extending the enable mask makes out-of-range codes read as disabled.
    assign en_ext  = NSEL'(src_en);
    assign sel_ok  = en_ext[sel];
    assign eff_sel = sel_ok ? sel : DEF_SEL;

    always_comb begin
        eff_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eff_sel == SEL_W'(i)) begin
                eff_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    bus_skid_buf #(
        .W       (PW),
        .RST_VAL ({DEF_SEL, {DATA_W{1'b0}}})
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({eff_sel, eff_data}),
        .in_valid  (sel_valid),
        .in_ready  (sel_ready),
        .out_data  (buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = buf_out[DATA_W-1:0];
    assign out_sel  = buf_out[PW-1:DATA_W];

    assign accept  = sel_valid && sel_ready;
    assign consume = out_valid && out_ready;

    // Setting has priority so a clear cannot hide an error accepted in the same cycle.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && !sel_ok) begin
            sel_err_d = 1'b1;
        end else if (sel_err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    assign xfer_cnt_d = consume ? xfer_cnt_q + 1'b1 : xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_bus_src_mux_skid.sv
// tb/tb_bus_src_mux_skid.sv - directed self-checking bench for bus_src_mux_skid
module tb_bus_src_mux_skid;

    localparam int DATA_W = 24;
    localparam int N_SRC  = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [SEL_W-1:0]        sel;
    logic                    sel_valid;
    logic                    sel_ready;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_en;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;
    logic                    sel_err_clr;
    logic [CNT_W-1:0]        xfer_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_src_mux_skid #(
        .DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .DEFAULT_SEL(7), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .sel_ready   (sel_ready),
        .src_data    (src_data),
        .src_en      (src_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .sel_err     (sel_err),
        .sel_err_clr (sel_err_clr),
        .xfer_cnt    (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DATA_W-1:0] v);
        src_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_walk[6];
        exp_walk = '{128, 256, 32, 160, 32, 64};

        rst_n = 1'b0; sel = '0; sel_valid = 1'b0; src_data = '0;
        src_en = 8'h3F; out_ready = 1'b1; sel_err_clr = 1'b0;
        for (int i = 0; i < 6; i++) set_src(i, exp_walk[i]);
        set_src(6, 24'h000600);
        set_src(7, 24'h000777);
        step();
        step();
        rst_n = 1'b1;

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_out_sel",   out_sel, 7);
        check("rst_sel_ready", sel_ready, 1);
        check("rst_sel_err",   sel_err, 0);
        check("rst_xfer_cnt",  xfer_cnt, 0);

        // disabled source 6 falls back to source 7
        sel = 3'd6; sel_valid = 1'b1;
        step();
        check("t1_fb_valid", out_valid, 1);
        check("t1_fb_sel",   out_sel, 7);
        check("t1_fb_data",  out_data, 24'h000777);
        check("t1_fb_err",   sel_err, 1);
        sel = 3'd1;
        step();
        sel_valid = 1'b0;
        check("t1_s1_data", out_data, 256);
        check("t1_s1_sel",  out_sel, 1);
        sel_err_clr = 1'b1;
        step();
        sel_err_clr = 1'b0;
        check("t1_err_clr", sel_err, 0);
        check("t1_drained", out_valid, 0);
        check("t1_cnt",     xfer_cnt, 2);

        do_reset();
        sel_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = 3'(i);
            step();
            check($sformatf("t2_data%0d", i), out_data, exp_walk[i]);
            check($sformatf("t2_sel%0d", i), out_sel, i);
            check($sformatf("t2_rdy%0d", i), sel_ready, 1);
        end
        sel_valid = 1'b0;
        step();
        check("t2_cnt",   xfer_cnt, 6);
        check("t2_empty", out_valid, 0);

        out_ready = 1'b0;
        sel = 3'd2; sel_valid = 1'b1;
        step();
        sel = 3'd3;
        step();
        sel_valid = 1'b0;
        check("t3_two_rdy",  sel_ready, 0);
        check("t3_two_val",  out_valid, 1);
        check("t3_two_data", out_data, 32);
        set_src(2, 999);
        step();
        check("t4_snap_data", out_data, 32);
        check("t4_snap_sel",  out_sel, 2);
        out_ready = 1'b1;
        step();
        check("t3_second", out_data, 160);
        check("t3_rdy_back", sel_ready, 1);
        step();
        check("t3_empty", out_valid, 0);
        check("t3_cnt",   xfer_cnt, 8);
        set_src(2, 32);

        sel = 3'd7; sel_valid = 1'b1; sel_err_clr = 1'b1;
        step();
        sel_valid = 1'b0;
        check("t5_set_wins", sel_err, 1);
        check("t5_sel",      out_sel, 7);
        check("t5_data",     out_data, 24'h000777);
        step();
        sel_err_clr = 1'b0;
        check("t5_cleared", sel_err, 0);

        out_ready = 1'b0;
        sel = 3'd0; sel_valid = 1'b1;
        step();
        sel = 3'd1;
        step();
        sel_valid = 1'b0;
        check("t6_full", sel_ready, 0);
        do_reset();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_rdy",   sel_ready, 1);
        check("t6_rst_cnt",   xfer_cnt, 0);
        check("t6_rst_sel",   out_sel, 7);

        out_ready = 1'b1;
        sel = 3'd4; sel_valid = 1'b1;
        repeat (65535) step();
        sel_valid = 1'b0;
        step();
        check("t6_cnt_max", xfer_cnt, 16'hFFFF);
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        step();
        check("t6_cnt_wrap", xfer_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
